// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcode classes, function
// codes, field widths and the IF/ID and ID/EX pipeline bundle types.
package isa_pkg;

    localparam int DATA_W  = 16;
    localparam int NREGS   = 8;
    localparam int REG_AW  = 3;
    localparam int OPC_W   = 6;
    localparam int FUNC_W  = 4;
    localparam int SHAMT_W = 4;

    // Opcode class lives in opcode[5:4]
    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_MEM  = 2'b01,
        CLS_RSV2 = 2'b10,
        CLS_RSV3 = 2'b11
    } op_class_e;

    // Function codes in opcode[3:0]
    localparam logic [FUNC_W-1:0] FN_NOP = 4'b0000;
    localparam logic [FUNC_W-1:0] FN_LDD = 4'b0001;
    localparam logic [FUNC_W-1:0] FN_STD = 4'b0010;
    localparam logic [FUNC_W-1:0] FN_LDM = 4'b0011;

    typedef struct packed {
        logic               valid;
        logic [OPC_W-1:0]   opcode;
        logic [REG_AW-1:0]  src;
        logic [REG_AW-1:0]  dst;
        logic [SHAMT_W-1:0] shamt;
    } if_id_t;

    typedef struct packed {
        logic               valid;
        logic [FUNC_W-1:0]  alu_op;
        logic               reg_we;
        logic               mem_rd;
        logic               mem_wr;
        logic               use_imm;
        logic [REG_AW-1:0]  src_idx;
        logic [REG_AW-1:0]  dst_idx;
        logic [DATA_W-1:0]  src_val;
        logic [DATA_W-1:0]  dst_val;
        logic [DATA_W-1:0]  imm;
    } id_ex_t;

    function automatic logic [DATA_W-1:0] zext_imm(
        input logic [SHAMT_W-1:0] s
    );
        return {{(DATA_W-SHAMT_W){1'b0}}, s};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8 x DATA_W register file: two combinational read ports, one write port
// written on the rising edge, synchronous active-high reset to zero.
// Ports: clk, rst, raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o,
//        we_i, waddr_i, wdata_i.
// Option: WB_BYPASS_EN defined -> a read of the index being written in the
// same cycle returns the write data; undefined -> returns the old value.
module reg_file
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef WB_BYPASS_EN
    // Write-through: writeback result is visible to decode this cycle
    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
        if (we_i && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
        if (we_i && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end
`else
    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// Pipeline stage 2: IF/ID latch, opcode decoder, register-file read,
// load-use hazard detection and the registered ID/EX bundle.
// Inputs : clk, rst (sync, active high), opcode/src/dst/shiftamount,
//          if_valid, flush, wb_en/wb_addr/wb_data (register-file write).
// Outputs: stall (comb), ex_* ID/EX bundle, illegal (one-cycle pulse).
// Option : WB_BYPASS_EN selects write-through register-file reads.
module decode_stage
    import isa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [REG_AW-1:0]  src,
    input  logic [REG_AW-1:0]  dst,
    input  logic [SHAMT_W-1:0] shiftamount,
    input  logic               if_valid,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               stall,
    output logic               ex_valid,
    output logic [FUNC_W-1:0]  ex_alu_op,
    output logic               ex_reg_we,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               ex_use_imm,
    output logic [REG_AW-1:0]  ex_src_idx,
    output logic [REG_AW-1:0]  ex_dst_idx,
    output logic [DATA_W-1:0]  ex_src_val,
    output logic [DATA_W-1:0]  ex_dst_val,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               illegal
);

    if_id_t ifid_q, ifid_d;
    id_ex_t idex_q, idex_d;
    logic   illegal_q, illegal_d;

    logic [DATA_W-1:0] src_val, dst_val;

    op_class_e         cls;
    logic [FUNC_W-1:0] func;
    id_ex_t            dec;
    logic              dec_illegal;
    logic              use_src, use_dst;
    logic              hz_src, hz_dst;
    logic              load_use;

    reg_file u_rf (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (ifid_q.src),
        .rdata_a_o (src_val),
        .raddr_b_i (ifid_q.dst),
        .rdata_b_o (dst_val),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    assign cls  = op_class_e'(ifid_q.opcode[5:4]);
    assign func = ifid_q.opcode[3:0];

    // Decode of the instruction currently in IF/ID
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        use_src     = 1'b0;
        use_dst     = 1'b0;

        dec.valid   = 1'b1;
        dec.src_idx = ifid_q.src;
        dec.dst_idx = ifid_q.dst;
        dec.src_val = src_val;
        dec.dst_val = dst_val;
        dec.imm     = zext_imm(ifid_q.shamt);

        unique case (cls)
            CLS_ALU: begin
                dec.alu_op = func;
                if (func != FN_NOP) begin
                    dec.reg_we = 1'b1;
                    use_src    = 1'b1;
                    use_dst    = 1'b1;
                end
            end
            CLS_MEM: begin
                unique case (func)
                    FN_LDD: begin
                        dec.mem_rd = 1'b1;
                        dec.reg_we = 1'b1;
                        use_src    = 1'b1;
                    end
                    FN_STD: begin
                        dec.mem_wr = 1'b1;
                        use_src    = 1'b1;
                        use_dst    = 1'b1;
                    end
                    FN_LDM: begin
                        dec.reg_we  = 1'b1;
                        dec.use_imm = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load in ID/EX whose destination feeds the instruction in IF/ID
    assign hz_src   = use_src && (idex_q.dst_idx == ifid_q.src);
    assign hz_dst   = use_dst && (idex_q.dst_idx == ifid_q.dst);
    assign load_use = ifid_q.valid && idex_q.valid && idex_q.mem_rd
                      && (hz_src || hz_dst);

    // A flush squashes whatever would have stalled
    assign stall = load_use && !flush;

    always_comb begin
        ifid_d    = ifid_q;
        idex_d    = '0;
        illegal_d = 1'b0;

        if (flush) begin
            ifid_d = '0;
        end else if (!load_use) begin
            if (if_valid) begin
                ifid_d.valid  = 1'b1;
                ifid_d.opcode = opcode;
                ifid_d.src    = src;
                ifid_d.dst    = dst;
                ifid_d.shamt  = shiftamount;
            end else begin
                ifid_d = '0;
            end
        end

        // Illegal opcodes leave a bubble behind and raise a pulse
        if (!flush && !load_use && ifid_q.valid) begin
            if (dec_illegal) begin
                illegal_d = 1'b1;
            end else begin
                idex_d = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q    <= '0;
            idex_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            ifid_q    <= ifid_d;
            idex_q    <= idex_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid   = idex_q.valid;
    assign ex_alu_op  = idex_q.alu_op;
    assign ex_reg_we  = idex_q.reg_we;
    assign ex_mem_rd  = idex_q.mem_rd;
    assign ex_mem_wr  = idex_q.mem_wr;
    assign ex_use_imm = idex_q.use_imm;
    assign ex_src_idx = idex_q.src_idx;
    assign ex_dst_idx = idex_q.dst_idx;
    assign ex_src_val = idex_q.src_val;
    assign ex_dst_val = idex_q.dst_val;
    assign ex_imm     = idex_q.imm;
    assign illegal    = illegal_q;

endmodule
